// File: rtl/lock_keypad_pkg.sv
// Shared keypad/lock definitions: key codes, scan classes, FSM states and
// the key-index to code lookup used by both the encoder and the lock.
package lock_keypad_pkg;

  localparam logic [3:0] KEY_NONE   = 4'b1111;
  localparam logic [3:0] KEY_SET    = 4'b1110;
  localparam logic [3:0] KEY_CANCEL = 4'b1101;
  localparam int         NUM_KEYS   = 12;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_cls_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } kp_state_t;

  // Key index is row*3 + column; row 3 holds '*', '0', '#'.
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd9:    code = KEY_CANCEL;
      4'd10:   code = 4'b0000;
      4'd11:   code = KEY_SET;
      default: code = (idx <= 4'd8) ? idx + 4'd1 : KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_code_encoder_if.sv
// Keypad matrix pins plus the key-code bus toward the lock.
interface keypad_code_encoder_if;
  logic [3:0] row_in;
  logic [2:0] col_out;
  logic [3:0] code_out;
  logic       code_valid;
  logic       key_held;

  modport master (
    input  row_in,
    output col_out,
    output code_out,
    output code_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  code_out,
    input  code_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_code_encoder_scan_ctrl.sv
// Column scanner: synchronises rows, drives columns, samples each column at
// the end of its slot and classifies the completed scan.
module keypad_scan_ctrl
  import lock_keypad_pkg::*;
#(
  parameter int SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [2:0] col_out,
  output logic       scan_done,
  output scan_cls_t  scan_cls,
  output logic [3:0] scan_key
);

  localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

  logic [3:0]        row_s1;
  logic [3:0]        row_s2;
  logic [SLOT_W-1:0] slot;
  logic [1:0]        col;
  logic [11:0]       key_map;
  logic [11:0]       scan_map;
  logic [3:0]        key_cnt;
  logic [3:0]        key_idx;
  logic              sample;
  logic [3:0]        pressed;

  assign sample  = (slot == SLOT_LAST);
  assign pressed = ~row_s2;

  // Two-flop synchroniser; cleared to the idle (all released) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  // Slot counter wraps every SCAN_DIV clocks and advances the column 0->1->2.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      col  <= 2'd0;
    end else if (sample) begin
      slot <= '0;
      col  <= (col == 2'd2) ? 2'd0 : col + 2'd1;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  // Record which keys of the current column are down at the slot's last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_map <= '0;
    end else if (sample) begin
      for (int c = 0; c < 3; c++) begin
        if (col == 2'(c)) begin
          for (int r = 0; r < 4; r++) key_map[r*3+c] <= pressed[r];
        end
      end
    end
  end

  // Active-low one-hot column drive.
  always_comb begin
    case (col)
      2'd1:    col_out = 3'b101;
      2'd2:    col_out = 3'b011;
      default: col_out = 3'b110;
    endcase
  end

  // Column 2 is taken live from the synchroniser so the result is ready in
  // the sampling cycle itself; the FSM registers it on the same edge.
  always_comb begin
    scan_map = key_map;
    for (int r = 0; r < 4; r++) scan_map[r*3+2] = pressed[r];
    key_cnt = 4'd0;
    key_idx = 4'd0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (scan_map[k]) begin
        key_cnt = key_cnt + 4'd1;
        key_idx = 4'(k);
      end
    end
    scan_done = sample && (col == 2'd2);
    scan_key  = key_idx;
    if (key_cnt == 4'd0)      scan_cls = SCAN_NONE;
    else if (key_cnt == 4'd1) scan_cls = SCAN_SINGLE;
    else                      scan_cls = SCAN_MULTI;
  end

endmodule

// File: rtl/keypad_code_encoder.sv
// Keypad code encoder top: debounce FSM over completed scans and the
// registered key-code outputs toward the lock.
//
//   state       | meaning
//   ST_IDLE     | no key accepted, waiting for a single-key scan
//   ST_DEBOUNCE | candidate seen in cnt consecutive scans
//   ST_HELD     | code emitted, key(s) still down
//   ST_RELEASE  | cnt consecutive empty scans seen since hold
module keypad_code_encoder
  import lock_keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  keypad_code_encoder_if.master kp
);

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

  logic       scan_done;
  scan_cls_t  scan_cls;
  logic [3:0] scan_key;
  logic [2:0] col_drv;

  kp_state_t  state;
  logic [3:0] cand;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic [3:0] code_q;
  logic       valid_q;
  logic       held_q;

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .row_in    (kp.row_in),
    .col_out   (col_drv),
    .scan_done (scan_done),
    .scan_cls  (scan_cls),
    .scan_key  (scan_key)
  );

  assign cnt_inc       = cnt + 4'd1;
  assign kp.col_out    = col_drv;
  assign kp.code_out   = code_q;
  assign kp.code_valid = valid_q;
  assign kp.key_held   = held_q;

  // Debounce FSM, stepped once per completed scan; emission lasts one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cand    <= 4'd0;
      cnt     <= 4'd0;
      code_q  <= KEY_NONE;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      code_q  <= KEY_NONE;
      if (scan_done) begin
        case (state)
          ST_IDLE: begin
            if (scan_cls == SCAN_SINGLE) begin
              cand <= scan_key;
              if (DEB_N <= 4'd1) begin
                state   <= ST_HELD;
                cnt     <= 4'd0;
                held_q  <= 1'b1;
                valid_q <= 1'b1;
                code_q  <= key_code(scan_key);
              end else begin
                state <= ST_DEBOUNCE;
                cnt   <= 4'd1;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (scan_cls != SCAN_SINGLE) begin
              state <= ST_IDLE;
              cnt   <= 4'd0;
            end else if (scan_key != cand) begin
              cand <= scan_key;
              cnt  <= 4'd1;
            end else if (cnt_inc >= DEB_N) begin
              state   <= ST_HELD;
              cnt     <= 4'd0;
              held_q  <= 1'b1;
              valid_q <= 1'b1;
              code_q  <= key_code(cand);
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_HELD: begin
            if (scan_cls == SCAN_NONE) begin
              if (DEB_N <= 4'd1) begin
                state  <= ST_IDLE;
                cnt    <= 4'd0;
                held_q <= 1'b0;
              end else begin
                state <= ST_RELEASE;
                cnt   <= 4'd1;
              end
            end
          end
          ST_RELEASE: begin
            if (scan_cls != SCAN_NONE) begin
              state <= ST_HELD;
              cnt   <= 4'd0;
            end else if (cnt_inc >= DEB_N) begin
              state  <= ST_IDLE;
              cnt    <= 4'd0;
              held_q <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_code_encoder.sv
// Self-checking bench for keypad_code_encoder: a keypad matrix model, a
// scan-level reference of the debounce rules and per-cycle output checks.
module tb_keypad_code_encoder;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int PERIOD   = 3 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_code_encoder_if kp ();

  keypad_code_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  // Keys currently held down, bit index = row*3 + column.
  logic [11:0] pressed = '0;

  // Matrix model: a held key pulls its row low while its column is driven.
  always_comb begin
    kp.row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!kp.col_out[c] && pressed[r*3+c]) kp.row_in[r] = 1'b0;
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  int         t     = 0;
  int         pulses = 0;
  int         hist[$];
  bit         held_m = 0;
  bit         emit_m = 0;
  logic [3:0] emit_code_m = 4'hF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  // -1 = no key, -2 = several keys, otherwise the single key's index.
  function automatic int classify(input logic [11:0] s);
    int n = $countones(s);
    if (n == 0) return -1;
    if (n > 1)  return -2;
    for (int k = 0; k < 12; k++) if (s[k]) return k;
    return -1;
  endfunction

  function automatic logic [3:0] code_of(input int k);
    int r = k / 3;
    int c = k % 3;
    if (r < 3)  return 4'(k + 1);
    if (c == 0) return 4'd13;
    if (c == 1) return 4'd0;
    return 4'd14;
  endfunction

  // Reference: a press is accepted when the last DEB scans show the same
  // single key while nothing is held; a release when the last DEB scans are
  // all empty while held.
  task automatic model_scan(input logic [11:0] s);
    bit same = 1;
    int last;
    hist.push_back(classify(s));
    if (hist.size() > 20) void'(hist.pop_front());
    last   = hist[hist.size()-1];
    emit_m = 0;
    if (hist.size() >= DEB) begin
      for (int i = 1; i < DEB; i++)
        if (hist[hist.size()-1-i] != last) same = 0;
      if (!held_m && last >= 0 && same) begin
        emit_m      = 1;
        emit_code_m = code_of(last);
        held_m      = 1;
      end else if (held_m && last == -1 && same) begin
        held_m = 0;
      end
    end
  endtask

  // One clock: check all outputs mid-cycle, then move past the next edge.
  task automatic step();
    logic [2:0] ce;
    bit         vexp;
    ce = 3'b111;
    ce[(t / SCAN_DIV) % 3] = 1'b0;
    vexp = ((t % PERIOD) == 0) && emit_m;
    @(negedge clk);
    check("col_out", 32'(kp.col_out), 32'(ce));
    check("code_valid", 32'(kp.code_valid), 32'(vexp));
    check("code_out", 32'(kp.code_out), vexp ? 32'(emit_code_m) : 32'hF);
    check("key_held", 32'(kp.key_held), 32'(held_m));
    if (kp.code_valid === 1'b1) pulses++;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run_scan(input logic [11:0] s, input int ncyc);
    pressed = s;
    for (int i = 0; i < ncyc; i++) step();
    if (ncyc == PERIOD) model_scan(s);
  endtask

  task automatic scans(input logic [11:0] s, input int n);
    for (int i = 0; i < n; i++) run_scan(s, PERIOD);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_col_out", 32'(kp.col_out), 32'h6);
      check("rst_code_out", 32'(kp.code_out), 32'hF);
      check("rst_code_valid", 32'(kp.code_valid), 32'h0);
      check("rst_key_held", 32'(kp.key_held), 32'h0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    t = 0;
    hist.delete();
    held_m = 0;
    emit_m = 0;
  endtask

  localparam logic [11:0] K1    = 12'(1) << 0;
  localparam logic [11:0] K5    = 12'(1) << 4;
  localparam logic [11:0] K7    = 12'(1) << 6;
  localparam logic [11:0] K9    = 12'(1) << 8;
  localparam logic [11:0] KSTAR = 12'(1) << 9;
  localparam logic [11:0] K0    = 12'(1) << 10;
  localparam logic [11:0] KHASH = 12'(1) << 11;

  initial begin
    // Reset and idle column stepping.
    do_reset(2);
    scans('0, 2);

    // Clean press of 5.
    pulses = 0;
    scans(K5, 10);
    scans('0, 4);
    check("t2_pulses", 32'(pulses), 32'd1);

    // Bounce on 0.
    pulses = 0;
    scans(K0, 2);
    scans('0, 1);
    scans(K0, 3);
    scans('0, 4);
    check("t3_pulses", 32'(pulses), 32'd1);

    // Two keys together, then 9 released.
    pulses = 0;
    scans(K1 | K9, 8);
    scans(K1, 4);
    scans('0, 4);
    check("t4_pulses", 32'(pulses), 32'd1);

    // '*' held, '#' added and removed, then full release and '#'.
    pulses = 0;
    scans(KSTAR, 4);
    scans(KSTAR | KHASH, 3);
    scans(KSTAR, 2);
    scans('0, 4);
    scans(KHASH, 4);
    scans('0, 4);
    check("t5_pulses", 32'(pulses), 32'd2);

    // Reset in the middle of debouncing 7.
    pulses = 0;
    run_scan(K7, PERIOD);
    run_scan(K7, 5);
    do_reset(3);
    check("t6_pre_pulses", 32'(pulses), 32'd0);
    scans(K7, 5);
    scans('0, 4);
    check("t6_pulses", 32'(pulses), 32'd1);

    // Random scan sequences with occasional mid-scan resets.
    for (int seg = 0; seg < 80; seg++) begin
      int          kind = $urandom_range(0, 9);
      int          len  = $urandom_range(1, 5);
      int          a    = $urandom_range(0, 11);
      int          b    = (a + 1 + $urandom_range(0, 10)) % 12;
      logic [11:0] s;
      if (kind < 3)      s = '0;
      else if (kind < 9) s = 12'(1) << a;
      else               s = (12'(1) << a) | (12'(1) << b);
      if ($urandom_range(0, 24) == 0) begin
        run_scan(s, $urandom_range(1, PERIOD - 1));
        do_reset($urandom_range(1, 3));
      end
      scans(s, len);
    end
    scans('0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_code_encoder.md
# keypad_code_encoder

Scans a 4×3 matrix keypad, debounces presses and emits one 4-bit key code per press, for exactly one clock. It is the transmitting end of the lock's keypad code interface: its `code_out` drives the lock's 4-bit user-input bus directly. That bus idles at 1111 and treats any other value as one keystroke per clock.

## Interface
Parameters:
- `SCAN_DIV`, default 16: clocks per column slot. Must be ≥4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans needed to accept a press, and consecutive empty scans needed to accept a release. Range 1..15.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `row_in` in 4: keypad rows, active-low with external pull-ups, asynchronous to `clk`.
- `col_out` out 3: column drive, active-low. Exactly one bit is low at any time.
- `code_out` out 4: key code. Holds 4'b1111 except for the single emission cycle.
- `code_valid` out 1: high exactly in the emission cycle.
- `key_held` out 1: high from emission until the release is accepted.

## Operation
- **Key map** (row r = 0..3, column c = 0..2):
  - Row 0: 1, 2, 3. Row 1: 4, 5, 6. Row 2: 7, 8, 9. Row 3: `*`, 0, `#`.
  - Digits 1..9 → 4'd1..4'd9. Digit 0 → 4'b0000.
  - `*` → 4'b1101 (cancel). `#` → 4'b1110 (set passcode). No key → 4'b1111.
- **Row synchronisation:** `row_in` passes through a 2-flop synchroniser before any use.
- **Column scan:**
  - A slot counter runs 0..SCAN_DIV-1. The column index cycles 0→1→2→0.
  - `col_out[c]` is low during slot c.
  - Synchronised rows are sampled on the last cycle of each slot.
  - After column 2 is sampled, the scan result is classified as NONE, SINGLE(key index 0..11) or MULTI (≥2 keys anywhere in the scan).
- **FSM (states IDLE, DEBOUNCE, HELD, RELEASE), evaluated once per completed scan:**
  - IDLE:
    - SINGLE(k) → DEBOUNCE with candidate=k, cnt=1.
    - NONE or MULTI → stay.
  - DEBOUNCE:
    - SINGLE(same k) → cnt+1.
    - SINGLE(different k) → candidate=new k, cnt=1.
    - NONE or MULTI → IDLE.
    - When cnt reaches DEBOUNCE_SCANS → HELD and emit the candidate's code.
    - With DEBOUNCE_SCANS=1, IDLE goes straight to HELD on the first SINGLE and emits.
  - HELD:
    - NONE → RELEASE with cnt=1.
    - SINGLE (any key) or MULTI → stay. No emission.
  - RELEASE:
    - NONE → cnt+1; when cnt reaches DEBOUNCE_SCANS → IDLE and `key_held`=0.
    - SINGLE or MULTI → back to HELD.
- **Emission:** one cycle of `code_out`=code with `code_valid`=1, then `code_out` returns to 1111.
- **Key changes:**
  - A second key pressed while the first is held is never emitted until a full release has been accepted.
  - Auto-repeat is not supported.
- **Reset (any time, including mid-scan or mid-debounce):**
  - `col_out`=3'b110, `code_out`=4'b1111, `code_valid`=0, `key_held`=0.
  - State IDLE; all counters and synchroniser flops cleared; candidate cleared.
  - A key already down at reset release must debounce from scratch and is emitted once.

## Timing
- **Scan period:** 3·SCAN_DIV clocks.
- **Row settling:** samples occur SCAN_DIV-1 cycles after the column switch. This leaves ≥1 cycle of settling after the 2-flop synchroniser, hence SCAN_DIV ≥4.
- **Emission latency:** `code_valid` is asserted the cycle after the final column-2 sample of the accepting scan. From first stable contact, emission takes DEBOUNCE_SCANS scans plus at most one partial scan plus 3 clocks.
- **Release:** `key_held` falls the cycle after the accepting release scan.
- **Output registers:** `code_out`, `code_valid` and `key_held` are all registered. There is no combinational path from `row_in`.
- **Counter widths:**
  - Slot counter: $clog2(SCAN_DIV) bits, wrapping at SCAN_DIV-1.
  - Debounce counter: 4 bits, saturating at DEBOUNCE_SCANS.

## Structure
- **Shared package `lock_keypad_pkg`:**
  - Code constants KEY_NONE=4'b1111, KEY_SET=4'b1110, KEY_CANCEL=4'b1101.
  - Key-index→code lookup function.
  - FSM state enum.
  - The lock consumes the same constants.
- **Sub-module `keypad_scan_ctrl`:** contains the synchroniser, slot and column counters, `col_out` drive and scan classification. It outputs a one-cycle `scan_done` strobe plus {NONE, SINGLE, MULTI, key index}.
- **Top level:** holds the debounce FSM and output registers.

## Test plan
Run with SCAN_DIV=4 and DEBOUNCE_SCANS=3 unless noted.
1. Reset: assert `rst` for 2 cycles → `col_out`=110, `code_out`=1111, `code_valid`=0, `key_held`=0. Then `col_out` steps 110→101→011 every 4 clocks.
2. Clean press of key 5 (row 1 low only while column 1 is driven) for 10 scans → exactly one `code_valid` pulse with `code_out`=4'd5, on the cycle after the 3rd full scan. `key_held`=1 until 3 empty scans after release.
3. Bounce: key 0 present for 2 scans, absent for 1 scan, then present for 3 scans → single emission of 4'b0000 after the last 3 scans. No earlier pulse.
4. MULTI: keys 1 and 9 pressed together for 8 scans → no emission. Release 9 with 1 still held → emission of 4'd1 after 3 scans.
5. Hold `*` and then press `#`; release `#` while still holding `*` → only 4'b1101 is emitted. A full release followed by a fresh `#` press → 4'b1110.
6. Assert `rst` during scan 2 of a DEBOUNCE on key 7 → no pulse. The key, still held after reset, is emitted as 4'd7 exactly once, 3 scans after reset release.
